// File: rtl/spi_adc_slave.sv
// AD7810-style serial ADC responder: powers up on CONVST, waits a fixed conversion
// delay, then shifts a latched WIDTH-bit code out MSB first on the master's SCLK.
module spi_adc_slave #(
  parameter int WIDTH          = 10,
  parameter int SPI_MODE       = 1,
  parameter int POWERUP_CYCLES = 150,
  parameter int CONV_CYCLES    = 230,
  parameter int SYNC_STAGES    = 0
) (
  input  logic             pll_clk,
  input  logic             rst,
  input  logic             convst,
  input  logic             sclk,
  input  logic [WIDTH-1:0] code_in,
  output logic             miso,
  output logic             busy,
  output logic             word_done,
  output logic [WIDTH-1:0] code_sent,
  output logic             protocol_err
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   CW   = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int   PW   = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int   BW   = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [PW-1:0] PWR_LAST  = PW'(POWERUP_CYCLES - 1);
  localparam logic [BW-1:0] BITS_FULL = BW'(WIDTH);
  localparam logic [BW-1:0] BITS_ONE  = BW'(1);

  typedef enum logic [2:0] {PWRDN, POWERUP, IDLE, CONVERT, SHIFT} state_t;

  state_t           state;
  logic [PW-1:0]    pwr_cnt;
  logic [CW-1:0]    conv_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] code_lat;

  logic cs_cur, sk_cur, cs_prev, sk_prev;
  logic cs_rise, cs_fall, sk_rise, sk_fall, sk_edge;
  logic lead, trail, last_edge;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign cs_cur = convst;
      assign sk_cur = sclk;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] cs_sync;
      logic [SYNC_STAGES-1:0] sk_sync;
      // sclk chain resets to its idle level so reset release is not seen as an edge
      always_ff @(posedge pll_clk) begin
        if (rst) begin
          cs_sync <= '0;
          sk_sync <= {SYNC_STAGES{CPOL}};
        end else begin
          cs_sync[0] <= convst;
          sk_sync[0] <= sclk;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            cs_sync[i] <= cs_sync[i-1];
            sk_sync[i] <= sk_sync[i-1];
          end
        end
      end
      assign cs_cur = cs_sync[SYNC_STAGES-1];
      assign sk_cur = sk_sync[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge pll_clk) begin
    if (rst) begin
      cs_prev <= 1'b0;
      sk_prev <= CPOL;
    end else begin
      cs_prev <= cs_cur;
      sk_prev <= sk_cur;
    end
  end

  always_comb begin
    cs_rise   = cs_cur & ~cs_prev;
    cs_fall   = ~cs_cur & cs_prev;
    sk_rise   = sk_cur & ~sk_prev;
    sk_fall   = ~sk_cur & sk_prev;
    sk_edge   = sk_rise | sk_fall;
    lead      = CPOL ? sk_fall : sk_rise;
    trail     = CPOL ? sk_rise : sk_fall;
    last_edge = trail && (CPHA ? (bit_cnt == '0) : (bit_cnt == BITS_ONE));
  end

  always_ff @(posedge pll_clk) begin
    if (rst) begin
      state        <= PWRDN;
      pwr_cnt      <= '0;
      conv_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      code_lat     <= '0;
      miso         <= 1'b0;
      busy         <= 1'b0;
      word_done    <= 1'b0;
      code_sent    <= '0;
      protocol_err <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        PWRDN: begin
          if (cs_rise) begin
            state   <= POWERUP;
            pwr_cnt <= '0;
          end
        end
        POWERUP: begin
          if (cs_fall) protocol_err <= 1'b1;
          if (pwr_cnt == PWR_LAST) state <= IDLE;
          else pwr_cnt <= pwr_cnt + 1'b1;
        end
        IDLE: begin
          if (sk_edge) protocol_err <= 1'b1;
          if (cs_fall) begin
            shreg    <= code_in;
            code_lat <= code_in;
            conv_cnt <= '0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          if (sk_edge || cs_fall) protocol_err <= 1'b1;
          if (conv_cnt == CONV_LAST) begin
            bit_cnt <= BITS_FULL;
            state   <= SHIFT;
            if (!CPHA) miso <= shreg[WIDTH-1];
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (CPHA) begin
            if (lead && bit_cnt != '0) begin
              miso    <= shreg[WIDTH-1];
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt - 1'b1;
            end
          end else if (trail && bit_cnt > BITS_ONE) begin
            miso    <= shreg[WIDTH-2];
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
          end
          if (last_edge) begin
            word_done <= 1'b1;
            code_sent <= code_lat;
            miso      <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            state     <= IDLE;
          end
          // a convst fall overrides the word end: abort, or chain straight into the next conversion
          if (cs_fall) begin
            if (!last_edge) protocol_err <= 1'b1;
            shreg    <= code_in;
            code_lat <= code_in;
            conv_cnt <= '0;
            miso     <= 1'b0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        default: state <= PWRDN;
      endcase
    end
  end

endmodule
